// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP         = 32'h00000013;

   function automatic logic is_misaligned(input logic [63:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction memory port, redirect input and decode handshake.
interface instr_fetch_if;

   logic        o_imem_req;
   logic [63:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;

   logic        i_redirect;
   logic [63:0] i_redirect_pc;

   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instr;
   logic [63:0] o_pc;
   logic        o_misaligned;

   modport master (
      output o_imem_req, o_imem_addr,
      input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
      input  i_redirect, i_redirect_pc,
      output o_valid, o_instr, o_pc, o_misaligned,
      input  i_ready
   );

   modport slave (
      input  o_imem_req, o_imem_addr,
      output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
      output i_redirect, i_redirect_pc,
      input  o_valid, o_instr, o_pc, o_misaligned,
      output i_ready
   );

endinterface

// File: rtl/instr_fetch.sv
// RV64 instruction fetch: PC, single-outstanding imem request, instruction register
// with valid/ready to decode, and redirect handling with stale-response kill.
import fetch_pkg::*;

module instr_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input logic           i_clk,
   input logic           i_rst_n,
   instr_fetch_if.master bus
);

   fetch_state_t state, state_n;
   logic [63:0]  pc, pc_n;
   logic [63:0]  opc, opc_n;
   logic [31:0]  instr, instr_n;
   logic         valid, valid_n;
   logic         mis, mis_n;
   logic         kill, kill_n;
   logic         tgt_mis;

   assign tgt_mis = is_misaligned(bus.i_redirect_pc);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= FETCH;
         pc    <= RESET_PC;
         opc   <= RESET_PC;
         instr <= 32'h0;
         valid <= 1'b0;
         mis   <= 1'b0;
         kill  <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         opc   <= opc_n;
         instr <= instr_n;
         valid <= valid_n;
         mis   <= mis_n;
         kill  <= kill_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      opc_n   = opc;
      instr_n = instr;
      valid_n = valid;
      mis_n   = mis;
      kill_n  = kill;

      // A redirect always retargets the PC and retires whatever sits in the IR.
      if (bus.i_redirect) begin
         pc_n    = bus.i_redirect_pc;
         valid_n = 1'b0;
         mis_n   = tgt_mis;
      end

      case (state)
         FETCH: begin
            if (bus.i_imem_gnt) begin
               state_n = WAIT;
               if (bus.i_redirect) kill_n = 1'b1;
            end else if (bus.i_redirect && tgt_mis) begin
               state_n = FAULT;
            end
         end
         WAIT: begin
            if (bus.i_redirect) kill_n = 1'b1;
            if (bus.i_imem_rvalid) begin
               // A stale response drains here; a pending misaligned target then faults.
               if (bus.i_redirect || kill) begin
                  kill_n  = 1'b0;
                  state_n = mis_n ? FAULT : FETCH;
               end else begin
                  instr_n = bus.i_imem_rdata;
                  opc_n   = pc;
                  valid_n = 1'b1;
                  state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.i_redirect) begin
               state_n = tgt_mis ? FAULT : FETCH;
            end else if (bus.i_ready) begin
               pc_n    = pc + 64'(INSTR_BYTES);
               valid_n = 1'b0;
               state_n = FETCH;
            end
         end
         FAULT: begin
            if (bus.i_redirect && !tgt_mis) state_n = FETCH;
         end
         default: state_n = FETCH;
      endcase
   end

   assign bus.o_imem_req   = (state == FETCH);
   assign bus.o_imem_addr  = pc;
   assign bus.o_valid      = valid;
   assign bus.o_instr      = instr;
   assign bus.o_pc         = opc;
   assign bus.o_misaligned = mis;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven fetches plus redirect, fault,
// wrap and asynchronous-reset sequences, with a scoreboard on decode transfers.
import fetch_pkg::*;

module tb_instr_fetch;

   typedef struct {
      int          gnt_dly;
      int          stall;
      logic [63:0] addr;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic i_clk;
   logic i_rst_n;
   int   n_tests;
   int   n_fail;
   logic dead_seen;
   exp_t sb[$];
   vec_t tbl[5];

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(64'h1000)) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .bus    (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      if (bus.o_valid && bus.i_ready && !bus.i_redirect) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_unexpected: got pc %h instr %h expected no transfer",
                     bus.o_pc, bus.o_instr);
         end else begin
            e = sb.pop_front();
            chk("xfer_pc", bus.o_pc, e.pc);
            chk("xfer_instr", {32'h0, bus.o_instr}, {32'h0, e.instr});
         end
      end
      if (bus.o_valid && bus.o_instr == 32'hDEADBEEF) dead_seen = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   task automatic fetch_one(input int dly, input int stall, input logic [63:0] addr,
                            input logic [31:0] data);
      exp_t e;
      for (int i = 0; i < dly; i++) begin
         chk("req_held", {63'h0, bus.o_imem_req}, 64'h1);
         chk("addr_held", bus.o_imem_addr, addr);
         bus.i_imem_gnt = 1'b0;
         tick();
      end
      chk("req", {63'h0, bus.o_imem_req}, 64'h1);
      chk("addr", bus.o_imem_addr, addr);
      bus.i_imem_gnt = 1'b1;
      e.pc = addr;
      e.instr = data;
      sb.push_back(e);
      tick();
      bus.i_imem_gnt = 1'b0;
      chk("wait_noreq", {63'h0, bus.o_imem_req}, 64'h0);
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = data;
      tick();
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = NOP;
      chk("hold_valid", {63'h0, bus.o_valid}, 64'h1);
      bus.i_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("stall_valid", {63'h0, bus.o_valid}, 64'h1);
         chk("stall_instr", {32'h0, bus.o_instr}, {32'h0, data});
         chk("stall_pc", bus.o_pc, addr);
      end
      bus.i_ready = 1'b1;
      tick();
      chk("post_xfer_valid", {63'h0, bus.o_valid}, 64'h0);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      dead_seen = 1'b0;
      tbl[0] = '{0, 0, 64'h1000, 32'h00500093};
      tbl[1] = '{0, 0, 64'h1004, 32'h00a00113};
      tbl[2] = '{0, 0, 64'h1008, 32'h002081b3};
      tbl[3] = '{4, 0, 64'h100C, 32'hfe010113};
      tbl[4] = '{2, 2, 64'h1010, 32'h00113423};

      bus.i_imem_gnt    = 1'b0;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = NOP;
      bus.i_redirect    = 1'b0;
      bus.i_redirect_pc = 64'h0;
      bus.i_ready       = 1'b1;
      i_rst_n           = 1'b0;
      #12;
      chk("rst_valid", {63'h0, bus.o_valid}, 64'h0);
      chk("rst_instr", {32'h0, bus.o_instr}, 64'h0);
      chk("rst_pc", bus.o_pc, 64'h1000);
      chk("rst_mis", {63'h0, bus.o_misaligned}, 64'h0);
      chk("rst_req", {63'h0, bus.o_imem_req}, 64'h1);
      chk("rst_addr", bus.o_imem_addr, 64'h1000);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      for (int v = 0; v < 5; v++) fetch_one(tbl[v].gnt_dly, tbl[v].stall, tbl[v].addr, tbl[v].data);

      // Redirect while waiting: the in-flight response must be dropped.
      bus.i_imem_gnt = 1'b1;
      tick();
      bus.i_imem_gnt    = 1'b0;
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h2000;
      tick();
      bus.i_redirect    = 1'b0;
      chk("kill_noreq", {63'h0, bus.o_imem_req}, 64'h0);
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'hDEADBEEF;
      tick();
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = NOP;
      chk("kill_valid", {63'h0, bus.o_valid}, 64'h0);
      fetch_one(0, 0, 64'h2000, 32'h0000006f);

      // Redirect in HOLD beats i_ready.
      bus.i_imem_gnt = 1'b1;
      tick();
      bus.i_imem_gnt    = 1'b0;
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'hA5A5A5A5;
      tick();
      bus.i_imem_rvalid = 1'b0;
      chk("hold_pre_valid", {63'h0, bus.o_valid}, 64'h1);
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h3000;
      bus.i_ready       = 1'b1;
      tick();
      bus.i_redirect = 1'b0;
      chk("hold_redir_valid", {63'h0, bus.o_valid}, 64'h0);
      chk("hold_redir_addr", bus.o_imem_addr, 64'h3000);
      fetch_one(0, 0, 64'h3000, 32'h00000073);

      // Misaligned redirect from FETCH, then recovery.
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h2002;
      tick();
      bus.i_redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("fault_mis", {63'h0, bus.o_misaligned}, 64'h1);
         chk("fault_noreq", {63'h0, bus.o_imem_req}, 64'h0);
         bus.i_imem_gnt = 1'b1;
         tick();
         bus.i_imem_gnt = 1'b0;
      end
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h4000;
      tick();
      bus.i_redirect = 1'b0;
      chk("fault_clear", {63'h0, bus.o_misaligned}, 64'h0);
      fetch_one(0, 0, 64'h4000, 32'h00100513);

      // Misaligned redirect while waiting: drain first, then fault.
      bus.i_imem_gnt = 1'b1;
      tick();
      bus.i_imem_gnt    = 1'b0;
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h5001;
      tick();
      bus.i_redirect = 1'b0;
      chk("wfault_mis", {63'h0, bus.o_misaligned}, 64'h1);
      chk("wfault_noreq", {63'h0, bus.o_imem_req}, 64'h0);
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'hDEADBEEF;
      tick();
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = NOP;
      tick();
      chk("wfault_noreq2", {63'h0, bus.o_imem_req}, 64'h0);
      chk("wfault_valid", {63'h0, bus.o_valid}, 64'h0);
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h4008;
      tick();
      bus.i_redirect = 1'b0;
      fetch_one(0, 0, 64'h4008, 32'h00b50533);

      // PC wrap at the top of the address space.
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      bus.i_redirect = 1'b0;
      fetch_one(0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h12345037);
      chk("wrap_addr", bus.o_imem_addr, 64'h0);

      // Asynchronous reset while a request is outstanding.
      bus.i_imem_gnt = 1'b1;
      tick();
      bus.i_imem_gnt = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'h0, bus.o_valid}, 64'h0);
      chk("arst_instr", {32'h0, bus.o_instr}, 64'h0);
      chk("arst_pc", bus.o_pc, 64'h1000);
      chk("arst_mis", {63'h0, bus.o_misaligned}, 64'h0);
      chk("arst_req", {63'h0, bus.o_imem_req}, 64'h1);
      chk("arst_addr", bus.o_imem_addr, 64'h1000);
      #2;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      fetch_one(0, 0, 64'h1000, 32'h00500093);

      chk("sb_empty", 64'(sb.size()), 64'h0);
      chk("dead_never_valid", {63'h0, dead_seen}, 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
